// File: rtl/pcie_lcrc_checker.sv
// LCRC checker: strips the trailing 4-byte LCRC and flags the last payload beat; one-beat holdback, one bubble per frame.
// Optional saturating error counter enabled by PCIE_LCRC_CHECKER_ERR_CNT_EN; otherwise err_count is tied to 0.
module pcie_lcrc_checker #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          s_axis_tdata,
  input  logic [3:0]           s_axis_tkeep,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [31:0]          m_axis_tdata,
  output logic [3:0]           m_axis_tkeep,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 crc_ok,
  output logic                 crc_err,
  output logic                 runt_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  state_t      state, state_nxt;
  logic [31:0] hold, lcrc, crc, crc_next;
  logic [3:0]  final_keep;
  logic [1:0]  in_sel;
  logic        s_hs, m_hs, crc_bad;
  logic        crc_ok_q, crc_err_q, runt_q;

  // Byte-select CRC step: folds bytes 0..sel of d into c, LSB-first per byte.
  function automatic logic [31:0] crc_bytes(input logic [31:0] c, input logic [31:0] d,
                                            input logic [1:0] sel);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 32; i++) begin
      if (i < 8 * (int'(sel) + 1))
        r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [1:0] keep_sel(input logic [3:0] k);
    case (k)
      4'b0001: return 2'd0;
      4'b0011: return 2'd1;
      4'b0111: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tkeep  = 4'h0;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && !s_axis_tlast) state_nxt = RUN;
      end
      RUN: begin
        s_axis_tready = s_axis_tlast | m_axis_tready;
        m_axis_tvalid = s_axis_tvalid & ~s_axis_tlast;
        m_axis_tkeep  = 4'hF;
        if (s_axis_tvalid && s_axis_tlast) state_nxt = FINAL;
      end
      FINAL: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = final_keep;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_sel       = keep_sel(s_axis_tkeep);
  assign s_hs         = s_axis_tvalid & s_axis_tready;
  assign m_hs         = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata = hold;
  assign crc_next     = crc_bytes(crc, hold, keep_sel(m_axis_tkeep));
  assign crc_bad      = (~crc_next != lcrc);
  assign m_axis_tuser = (state == FINAL) && crc_bad;
  assign crc_ok       = crc_ok_q;
  assign crc_err      = crc_err_q;
  assign runt_err     = runt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= 32'h0;
      lcrc       <= 32'h0;
      final_keep <= 4'h0;
      crc        <= CRC_INIT;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
      runt_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      crc_ok_q  <= 1'b0;
      crc_err_q <= 1'b0;
      runt_q    <= s_hs && s_axis_tlast && (state == IDLE);
      if (s_hs && !s_axis_tlast) hold <= s_axis_tdata;
      // The LCRC straddles hold and the last beat; hold bytes come first on the wire.
      if (s_hs && s_axis_tlast && (state == RUN)) begin
        case (in_sel)
          2'd0:    begin lcrc <= {s_axis_tdata[7:0],  hold[31:8]};  final_keep <= 4'b0001; end
          2'd1:    begin lcrc <= {s_axis_tdata[15:0], hold[31:16]}; final_keep <= 4'b0011; end
          2'd2:    begin lcrc <= {s_axis_tdata[23:0], hold[31:24]}; final_keep <= 4'b0111; end
          default: begin lcrc <= s_axis_tdata;                       final_keep <= 4'b1111; end
        endcase
      end
      if (m_hs) begin
        if (state == FINAL) begin
          crc       <= CRC_INIT;
          crc_ok_q  <= ~crc_bad;
          crc_err_q <= crc_bad;
        end else begin
          crc <= crc_next;
        end
      end
    end
  end

`ifdef PCIE_LCRC_CHECKER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W:0]   err_sum;

  assign err_sum   = {1'b0, err_cnt_q} + (ERR_CNT_W+1)'(crc_err_q) + (ERR_CNT_W+1)'(runt_q);
  assign err_count = err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_cnt_q <= '0;
    else if (err_sum[ERR_CNT_W]) err_cnt_q <= '1;
    else                     err_cnt_q <= err_sum[ERR_CNT_W-1:0];
  end
`else
  assign err_count = '0;
`endif

endmodule
